// File: rtl/conv_pkg.sv
// Shared constants and types for the 1-D convolution engine controllers.
package conv_pkg;

    localparam int X_LEN  = 43;
    localparam int F_LEN  = 16;
    localparam int DATA_W = 32;
    localparam int XA_W   = 6;
    localparam int FA_W   = 4;
    localparam int Y_LEN  = X_LEN - F_LEN + 1;

    typedef enum logic {
        LOAD = 1'b0,
        CONV = 1'b1
    } in_state_t;

endpackage

// File: rtl/stream_wr_cnt.sv
// Per-stream write counter: turns a valid/ready stream into sequential
// memory writes and reports when LEN entries have been written.
module stream_wr_cnt #(
    parameter int LEN = 16,
    parameter int AW  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    input  logic          valid,
    output logic          ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          full,
    output logic          full_nxt
);

    // The count must be able to hold LEN itself so that "full" is exact.
    localparam int CW = ($clog2(LEN + 1) > AW) ? $clog2(LEN + 1) : AW;

    logic [CW-1:0] cnt;
    logic          last;

    // Ready, write strobe and address are all zero-latency functions of the count.
    always_comb begin
        full     = (cnt == CW'(LEN));
        last     = (cnt == CW'(LEN - 1));
        ready    = enable & ~full;
        wr_en    = valid & ready;
        wr_addr  = cnt[AW-1:0];
        full_nxt = full | (wr_en & last);
    end

    // Count accepted transfers; a clear restarts the frame at address 0.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (wr_en) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ctrl_conv_input.sv
// Input-side controller of the 1-D convolution engine. Receives the x and f
// streams, writes them into x/f memory, then holds conv_start until the output
// controller reports conv_done.
// Optional macro CTRL_CONV_INPUT_FILTER_PERSIST_EN: filter taps are loaded only
// once after reset and reused by every later frame.
module ctrl_conv_input
    import conv_pkg::*;
#(
    parameter int X_LEN  = conv_pkg::X_LEN,
    parameter int F_LEN  = conv_pkg::F_LEN,
    parameter int DATA_W = conv_pkg::DATA_W,
    parameter int XA_W   = conv_pkg::XA_W,
    parameter int FA_W   = conv_pkg::FA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid_x,
    input  logic [DATA_W-1:0] s_data_x,
    output logic              s_ready_x,
    input  logic              s_valid_f,
    input  logic [DATA_W-1:0] s_data_f,
    output logic              s_ready_f,
    input  logic              conv_done,
    output logic              conv_start,
    output logic              xmem_wr_en,
    output logic [XA_W-1:0]   xmem_wr_addr,
    output logic [DATA_W-1:0] xmem_wr_data,
    output logic              fmem_wr_en,
    output logic [FA_W-1:0]   fmem_wr_addr,
    output logic [DATA_W-1:0] fmem_wr_data
);

    in_state_t state, next_state;

    logic load_en;
    logic frame_end;
    logic clear_x;
    logic clear_f;
    logic x_full, x_full_nxt;
    logic f_full, f_full_nxt;

    stream_wr_cnt #(.LEN(X_LEN), .AW(XA_W)) u_x_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear_x),
        .enable   (load_en),
        .valid    (s_valid_x),
        .ready    (s_ready_x),
        .wr_en    (xmem_wr_en),
        .wr_addr  (xmem_wr_addr),
        .full     (x_full),
        .full_nxt (x_full_nxt)
    );

    stream_wr_cnt #(.LEN(F_LEN), .AW(FA_W)) u_f_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear_f),
        .enable   (load_en),
        .valid    (s_valid_f),
        .ready    (s_ready_f),
        .wr_en    (fmem_wr_en),
        .wr_addr  (fmem_wr_addr),
        .full     (f_full),
        .full_nxt (f_full_nxt)
    );

    assign xmem_wr_data = s_data_x;
    assign fmem_wr_data = s_data_f;

    // Next-state logic; the LOAD exit also looks at the transfer completing this cycle.
    always_comb begin
        next_state = state;
        load_en    = 1'b0;
        frame_end  = 1'b0;
        unique case (state)
            LOAD: begin
                load_en = 1'b1;
                if (x_full_nxt && f_full_nxt) begin
                    next_state = CONV;
                end
            end
            CONV: begin
                if (conv_done) begin
                    frame_end  = 1'b1;
                    next_state = LOAD;
                end
            end
            default: next_state = LOAD;
        endcase
    end

    // Frame-end clearing; with persistent filters the tap counter stays full
    // so later frames need only the x stream to complete.
    always_comb begin
        clear_x = frame_end;
`ifdef CTRL_CONV_INPUT_FILTER_PERSIST_EN
        clear_f = 1'b0;
`else
        clear_f = frame_end;
`endif
    end

    // State register plus registered conv_start, which tracks the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LOAD;
            conv_start <= 1'b0;
        end else begin
            state      <= next_state;
            conv_start <= (next_state == CONV);
        end
    end

    // Full flags are implied by the state machine; they are kept for visibility only.
    logic unused_full;
    assign unused_full = x_full ^ f_full;

endmodule

// File: tb/tb_ctrl_conv_input.sv
// Scoreboard testbench for ctrl_conv_input: stimulus pushes per-cycle expected
// responses, a monitor pops and compares them on the falling edge.
module tb_ctrl_conv_input;
    import conv_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              s_valid_x, s_valid_f, conv_done;
    logic [DATA_W-1:0] s_data_x, s_data_f;
    logic              s_ready_x, s_ready_f, conv_start;
    logic              xmem_wr_en, fmem_wr_en;
    logic [XA_W-1:0]   xmem_wr_addr;
    logic [FA_W-1:0]   fmem_wr_addr;
    logic [DATA_W-1:0] xmem_wr_data, fmem_wr_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic              rx;
        logic              rf;
        logic              start;
        logic              xe;
        logic [XA_W-1:0]   xa;
        logic [DATA_W-1:0] xd;
        logic              fe;
        logic [FA_W-1:0]   fa;
        logic [DATA_W-1:0] fd;
    } exp_t;

    exp_t q[$];

    int  m_x;
    int  m_f;
    bit  m_conv;

    ctrl_conv_input dut (
        .clk          (clk),
        .reset        (reset),
        .s_valid_x    (s_valid_x),
        .s_data_x     (s_data_x),
        .s_ready_x    (s_ready_x),
        .s_valid_f    (s_valid_f),
        .s_data_f     (s_data_f),
        .s_ready_f    (s_ready_f),
        .conv_done    (conv_done),
        .conv_start   (conv_start),
        .xmem_wr_en   (xmem_wr_en),
        .xmem_wr_addr (xmem_wr_addr),
        .xmem_wr_data (xmem_wr_data),
        .fmem_wr_en   (fmem_wr_en),
        .fmem_wr_addr (fmem_wr_addr),
        .fmem_wr_data (fmem_wr_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus: drive inputs, predict the response, advance the model.
    task automatic applyStimulus(input bit vx, input logic [DATA_W-1:0] dx,
                                 input bit vf, input logic [DATA_W-1:0] df,
                                 input bit done);
        exp_t e;
        bit   tx, tf;
        s_valid_x = vx;
        s_data_x  = dx;
        s_valid_f = vf;
        s_data_f  = df;
        conv_done = done;
        e.rx    = !m_conv && (m_x < X_LEN);
        e.rf    = !m_conv && (m_f < F_LEN);
        e.start = m_conv;
        tx      = vx && e.rx;
        tf      = vf && e.rf;
        e.xe    = tx;
        e.xa    = XA_W'(m_x);
        e.xd    = dx;
        e.fe    = tf;
        e.fa    = FA_W'(m_f);
        e.fd    = df;
        q.push_back(e);
        if (tx) m_x++;
        if (tf) m_f++;
        if (!m_conv) begin
            if (m_x == X_LEN && m_f == F_LEN) m_conv = 1'b1;
        end else if (done) begin
            m_conv = 1'b0;
            m_x    = 0;
`ifndef CTRL_CONV_INPUT_FILTER_PERSIST_EN
            m_f    = 0;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset     = 1'b1;
        s_valid_x = 1'b0;
        s_valid_f = 1'b0;
        conv_done = 1'b0;
        s_data_x  = '0;
        s_data_f  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        m_x    = 0;
        m_f    = 0;
        m_conv = 1'b0;
    endtask

    // Monitor: compare every presented cycle against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && q.size() > 0) begin
                e = q.pop_front();
                checkOutput("s_ready_x",  32'(s_ready_x),  32'(e.rx));
                checkOutput("s_ready_f",  32'(s_ready_f),  32'(e.rf));
                checkOutput("conv_start", 32'(conv_start), 32'(e.start));
                checkOutput("xmem_wr_en", 32'(xmem_wr_en), 32'(e.xe));
                checkOutput("fmem_wr_en", 32'(fmem_wr_en), 32'(e.fe));
                if (e.xe) begin
                    checkOutput("xmem_wr_addr", 32'(xmem_wr_addr), 32'(e.xa));
                    checkOutput("xmem_wr_data", 32'(xmem_wr_data), 32'(e.xd));
                end
                if (e.fe) begin
                    checkOutput("fmem_wr_addr", 32'(fmem_wr_addr), 32'(e.fa));
                    checkOutput("fmem_wr_data", 32'(fmem_wr_data), 32'(e.fd));
                end
            end
        end
    end

    // Watchdog so the run always ends with a summary.
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        doReset();

        // Frame 1: both streams continuous, x[i]=i, f[j]=100+j; then 20 CONV cycles with x valid held.
        $display("[TB] frame 1: continuous load");
        for (int c = 0; c < 45; c++) applyStimulus(1'b1, DATA_W'(m_x), 1'b1, DATA_W'(100 + m_f), 1'b0);
        for (int c = 0; c < 20; c++) applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);

        // Frame 2: x valid every other cycle, f continuous, random data.
        $display("[TB] frame 2: toggling x valid");
        for (int c = 0; c < 95; c++) applyStimulus(c % 2 == 0, DATA_W'($urandom), 1'b1, DATA_W'($urandom), 1'b0);
        applyStimulus(1'b1, 32'h1234_5678, 1'b0, '0, 1'b1);

        // Frame 3: conv_done in LOAD after 10 x transfers must be ignored.
        $display("[TB] frame 3: conv_done during load");
        for (int c = 0; c < 10; c++) applyStimulus(1'b1, DATA_W'(c + 500), 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        for (int c = 0; c < 40; c++) applyStimulus(1'b1, DATA_W'(c + 600), 1'b1, DATA_W'(c + 700), 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);

        // Frame 4: reset after 30 x / 5 f transfers, then a clean reload.
        $display("[TB] frame 4: reset mid-load");
        for (int c = 0; c < 30; c++) applyStimulus(1'b1, DATA_W'(c), c < 5, DATA_W'(c + 50), 1'b0);
        doReset();
        for (int c = 0; c < 46; c++) applyStimulus(1'b1, DATA_W'(c + 900), 1'b1, DATA_W'(c + 800), 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);

        @(negedge clk);
        checkOutput("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_conv_input.md
Name: ctrl_conv_input

Overview:
- Input-side controller for the 1-D convolution engine: the stream receiver (slave end) for the x and f data streams.
- Accepts X_LEN input samples and F_LEN filter taps over two independent valid/ready streams.
- Writes them into x memory and f memory, then raises conv_start for the output controller.
- Holds conv_start until that controller's conv_done pulse, then re-arms for the next frame.

Parameters:
- X_LEN, 43, number of x samples per frame
- F_LEN, 16, number of filter taps
- DATA_W, 32, sample/tap width in bits
- XA_W, 6, x memory address width; must be at least clog2(X_LEN)
- FA_W, 4, f memory address width; must be at least clog2(F_LEN)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- s_valid_x  input  1  x stream data valid
- s_data_x  input  DATA_W  x stream sample
- s_ready_x  output  1  x stream ready
- s_valid_f  input  1  f stream data valid
- s_data_f  input  DATA_W  f stream tap
- s_ready_f  output  1  f stream ready
- conv_done  input  1  one-cycle pulse from the output controller; frame finished
- conv_start  output  1  memories loaded; convolution may run
- xmem_wr_en  output  1  x memory write enable
- xmem_wr_addr  output  XA_W  x memory write address
- xmem_wr_data  output  DATA_W  x memory write data
- fmem_wr_en  output  1  f memory write enable
- fmem_wr_addr  output  FA_W  f memory write address
- fmem_wr_data  output  DATA_W  f memory write data

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Reset values:
  - state = LOAD
  - x_cnt = 0, f_cnt = 0
  - conv_start = 0
  - s_ready_x = 1 and s_ready_f = 1 (combinational from state/counters)
  - all write enables = 0
- States: LOAD, CONV.
- LOAD:
  - s_ready_x = (x_cnt < X_LEN). s_ready_f = (f_cnt < F_LEN).
  - A transfer occurs when valid and ready are both high in the same cycle.
  - The two streams are independent; both may transfer in the same cycle.
- Write path is combinational, zero latency:
  - xmem_wr_en = s_valid_x & s_ready_x; xmem_wr_addr = x_cnt; xmem_wr_data = s_data_x.
  - f path is identical, using f_cnt.
  - x_cnt and f_cnt increment on each transfer. There is no wrap; counters saturate at X_LEN / F_LEN because ready drops.
- s_data_x is ignored when no x transfer occurs. A valid held high with ready low stalls with no write.
- LOAD -> CONV:
  - Taken when both counters are full, including the cycle in which the last transfer completes them.
  - conv_start is registered: it rises the cycle after the final write, so memory is written before the engine reads.
- CONV:
  - s_ready_x = 0, s_ready_f = 0; no writes occur.
  - conv_start stays at 1.
- CONV -> LOAD:
  - On conv_done = 1, return to LOAD with x_cnt = 0 and f_cnt = 0.
  - conv_start falls on that same clock edge.
  - Ready returns to 1 the following cycle.
- conv_done in LOAD is ignored.
- Reset asserted mid-load or mid-conv: return to the reset state. Partially written memory contents are don't-care; they are overwritten on the next frame.
- Minimum frame load latency: max(X_LEN, F_LEN) cycles with both streams continuously valid (43 at defaults).

Optional Feature:
- Macro: CTRL_CONV_INPUT_FILTER_PERSIST_EN.
- Defined:
  - f_cnt is not cleared on conv_done. After the first frame, filter taps persist.
  - s_ready_f stays 0 until reset.
  - Later frames transition LOAD -> CONV on x_cnt full alone.
- Undefined: the filter is reloaded every frame, as described above.

Decomposition:
- Shared package conv_pkg holds:
  - constants X_LEN, F_LEN, DATA_W, XA_W, FA_W
  - Y_LEN = X_LEN - F_LEN + 1
  - typedef enum logic {LOAD, CONV} in_state_t
- Sub-module stream_wr_cnt (parameterised LEN, AW) is natural: one per stream. It generates ready, wr_en, wr_addr and a full flag, and provides a clear input.

Test Plan:
- Both streams continuously valid with data x[i] = i, f[j] = 100 + j:
  - 43 x writes at addresses 0..42 and 16 f writes at addresses 0..15.
  - conv_start = 1 on cycle 44; both readies 0 from that cycle.
- x stream with valid toggling every other cycle, f continuous:
  - No write in cycles where valid = 0; the address increments only on transfers.
  - conv_start rises one cycle after the 43rd x transfer.
- In CONV, hold s_valid_x = 1 for 20 cycles:
  - No xmem_wr_en; s_ready_x = 0.
  - Pulse conv_done: conv_start = 0 next cycle; s_ready_x = 1; next write goes to address 0.
- conv_done pulsed during LOAD after 10 x transfers -> ignored; x_cnt continues from 10.
- Reset asserted after 30 x and 5 f transfers:
  - Next frame writes restart at address 0 for both memories; conv_start stays 0 until both are full.
- With CTRL_CONV_INPUT_FILTER_PERSIST_EN, second frame:
  - s_ready_f = 0 throughout.
  - conv_start rises after 43 x transfers only.
